// File: rtl/dmux_nway_stream.sv
// Registered N-way valid/ready demultiplexer with a two-entry skid buffer.
// Optional macro DMUX_ZERO_UNSEL_EN zeroes every lane except the selected, valid one.
module dmux_nway_stream #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SEL_W-1:0]              in_sel,
    input  logic [WIDTH-1:0]              in_data,
    output logic [(2**SEL_W)-1:0]         out_valid,
    input  logic [(2**SEL_W)-1:0]         out_ready,
    output logic [(2**SEL_W)*WIDTH-1:0]   out_data,
    output logic                          busy
);

    localparam int NUM_WAYS = 2**SEL_W;

    logic             main_valid_q, main_valid_d;
    logic [SEL_W-1:0] main_sel_q,   main_sel_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [SEL_W-1:0] skid_sel_q,   skid_sel_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;

    logic accept;
    logic drain;

    // in_ready comes straight from a register so upstream sees no combinational path.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign drain    = main_valid_q && out_ready[main_sel_q];
    assign busy     = main_valid_q || skid_valid_q;

    always_comb begin
        // NOTE: every _d gets a hold default first so no branch can infer a latch.
        main_valid_d = main_valid_q;
        main_sel_d   = main_sel_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_sel_d   = skid_sel_q;
        skid_data_d  = skid_data_q;

        if (!main_valid_q) begin
            if (accept) begin
                main_valid_d = 1'b1;
                main_sel_d   = in_sel;
                main_data_d  = in_data;
            end
        end else if (!skid_valid_q) begin
            if (accept && drain) begin
                main_sel_d  = in_sel;
                main_data_d = in_data;
            end else if (accept) begin
                skid_valid_d = 1'b1;
                skid_sel_d   = in_sel;
                skid_data_d  = in_data;
            end else if (drain) begin
                main_valid_d = 1'b0;
            end
        end else if (drain) begin
            // Both full: skid slides into main, preserving acceptance order.
            main_sel_d   = skid_sel_q;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; data registers are
        // cleared too so out_data reads 0 after reset in broadcast mode.
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_sel_q   <= '0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_sel_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_sel_q   <= main_sel_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_sel_q   <= skid_sel_d;
            skid_data_q  <= skid_data_d;
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int k = 0; k < NUM_WAYS; k++) begin
            out_valid[k] = main_valid_q && (main_sel_q == SEL_W'(k));
`ifdef DMUX_ZERO_UNSEL_EN
            out_data[k*WIDTH +: WIDTH] = out_valid[k] ? main_data_q : '0;
`else
            out_data[k*WIDTH +: WIDTH] = main_data_q;
`endif
        end
    end

endmodule

// File: tb/tb_dmux_nway_stream.sv
// Self-checking bench for dmux_nway_stream: directed scenarios plus a random run,
// all compared against a depth-2 FIFO reference model.
module tb_dmux_nway_stream;

    localparam int W  = 16;
    localparam int SW = 3;
    localparam int NW = 8;

    typedef struct {
        logic [SW-1:0] sel;
        logic [W-1:0]  data;
    } word_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [SW-1:0]   in_sel;
    logic [W-1:0]    in_data;
    logic [NW-1:0]   out_valid;
    logic [NW-1:0]   out_ready;
    logic [NW*W-1:0] out_data;
    logic            busy;

    int checks = 0;
    int errors = 0;

    word_t        model_q[$];
    logic [W-1:0] hold_data;

    dmux_nway_stream #(.WIDTH(W), .SEL_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: an ordered queue of at most two accepted words; the head is presented.
    function automatic logic [NW-1:0] exp_valid();
        if (model_q.size() > 0) return NW'(1) << model_q[0].sel;
        return '0;
    endfunction

    function automatic logic [NW*W-1:0] exp_data();
        logic [NW*W-1:0] v;
        v = '0;
        for (int k = 0; k < NW; k++) begin
`ifdef DMUX_ZERO_UNSEL_EN
            if (model_q.size() > 0 && int'(model_q[0].sel) == k) v[k*W +: W] = model_q[0].data;
`else
            v[k*W +: W] = hold_data;
`endif
        end
        return v;
    endfunction

    // Advance one clock edge, updating the model from the inputs seen at that edge.
    task automatic tick();
        bit acc;
        bit drn;
        @(posedge clk);
        acc = rst_n && in_valid && (model_q.size() < 2);
        drn = rst_n && (model_q.size() > 0) && out_ready[model_q[0].sel];
        if (!rst_n) begin
            model_q.delete();
            hold_data = '0;
        end else begin
            if (drn) void'(model_q.pop_front());
            if (acc) model_q.push_back('{sel: in_sel, data: in_data});
        end
        if (model_q.size() > 0) hold_data = model_q[0].data;
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 3'd4;
        in_data   = 16'hBEEF;
        out_ready = '1;
        model_q.delete();
        hold_data = '0;
        tick();
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 8'h00) begin
            errors++;
            $display("FAIL reset_out_valid: got %h expected 00", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_out_data: got %h expected 0", out_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_single();
        logic [NW*W-1:0] want;
        out_ready = '1;
        in_valid  = 1'b1;
        in_sel    = 3'd5;
        in_data   = 16'hA5A5;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 8'b0010_0000) begin
            errors++;
            $display("FAIL single_valid: got %b expected 00100000", out_valid);
        end
        checks++;
        if (out_data[5*W +: W] !== 16'hA5A5) begin
            errors++;
            $display("FAIL single_lane5: got %h expected a5a5", out_data[5*W +: W]);
        end
`ifdef DMUX_ZERO_UNSEL_EN
        want = '0;
        want[5*W +: W] = 16'hA5A5;
`else
        want = {NW{16'hA5A5}};
`endif
        checks++;
        if (out_data !== want) begin
            errors++;
            $display("FAIL single_lanes: got %h expected %h", out_data, want);
        end
        tick();
        checks++;
        if (out_valid !== 8'h00) begin
            errors++;
            $display("FAIL single_one_cycle: got %b expected 00000000", out_valid);
        end
    endtask

    task automatic test_stream();
        out_ready = '1;
        for (int s = 0; s < NW; s++) begin
            in_valid = 1'b1;
            in_sel   = SW'(s);
            in_data  = 16'(16'h10 + s);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_in_ready[%0d]: got %b expected 1", s, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== NW'(1) << s || out_data[s*W +: W] !== 16'(16'h10 + s)) begin
                errors++;
                $display("FAIL stream_word[%0d]: got valid %b lane %h expected valid %b lane %h",
                         s, out_valid, out_data[s*W +: W], NW'(1) << s, 16'(16'h10 + s));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stream_drained: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_backpressure();
        word_t obs[$];
        word_t want[3];
        logic [SW-1:0] way;
        want[0] = '{sel: 3'd2, data: 16'h1};
        want[1] = '{sel: 3'd3, data: 16'h2};
        want[2] = '{sel: 3'd4, data: 16'h3};
        out_ready = 8'hFB;
        in_valid  = 1'b1;
        in_sel    = 3'd2;
        in_data   = 16'h1;
        tick();
        in_sel  = 3'd3;
        in_data = 16'h2;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_before_second: got %b expected 1", in_ready);
        end
        tick();
        in_sel  = 3'd4;
        in_data = 16'h3;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 8'h04) begin
                errors++;
                $display("FAIL bp_stalled[%0d]: got in_ready %b valid %b expected 0 / 00000100",
                         c, in_ready, out_valid);
            end
            tick();
        end
        out_ready = '1;
        for (int c = 0; c < 20 && (in_valid || busy); c++) begin
            if ((out_valid & out_ready) != '0) begin
                way = '0;
                for (int k = 0; k < NW; k++) if (out_valid[k]) way = SW'(k);
                obs.push_back('{sel: way, data: out_data[way*W +: W]});
            end
            if (in_valid && in_ready) begin
                tick();
                in_valid = 1'b0;
            end else begin
                tick();
            end
        end
        checks++;
        if (obs.size() != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d words expected 3", obs.size());
        end
        for (int i = 0; i < 3 && i < obs.size(); i++) begin
            checks++;
            if (obs[i].sel !== want[i].sel || obs[i].data !== want[i].data) begin
                errors++;
                $display("FAIL bp_order[%0d]: got way %0d data %h expected way %0d data %h",
                         i, obs[i].sel, obs[i].data, want[i].sel, want[i].data);
            end
        end
    endtask

    task automatic test_stability();
        logic [W-1:0] d;
        d         = 16'($urandom);
        out_ready = 8'hBF;
        in_valid  = 1'b1;
        in_sel    = 3'd6;
        in_data   = d;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            out_ready = 8'($urandom) & 8'hBF;
            tick();
            checks++;
            if (out_valid !== 8'h40 || out_data[6*W +: W] !== d) begin
                errors++;
                $display("FAIL stable[%0d]: got valid %b lane6 %h expected 01000000 / %h",
                         c, out_valid, out_data[6*W +: W], d);
            end
        end
        out_ready = '1;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 8'h00) begin
            errors++;
            $display("FAIL stable_release: got busy %b valid %b expected 0 / 0", busy, out_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = SW'($urandom);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
            tick();
            checks++;
            if (out_valid !== exp_valid() || out_data !== exp_data() ||
                in_ready !== (model_q.size() < 2) || busy !== (model_q.size() > 0)) begin
                errors++;
                $display("FAIL random[%0d]: got valid %b rdy %b busy %b data %h expected valid %b rdy %b busy %b data %h",
                         c, out_valid, in_ready, busy, out_data,
                         exp_valid(), model_q.size() < 2, model_q.size() > 0, exp_data());
            end
        end
        in_valid  = 1'b0;
        out_ready = '1;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = '0;
        in_valid  = 1'b1;
        in_sel    = 3'd1;
        in_data   = 16'h1111;
        tick();
        in_sel  = 3'd7;
        in_data = 16'h7777;
        tick();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_full: got in_ready %b busy %b expected 0 / 1", in_ready, busy);
        end
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = '1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: got busy %b valid %b expected 0 / 0", busy, out_valid);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (out_valid !== 8'h00) begin
                errors++;
                $display("FAIL mid_no_ghost[%0d]: got valid %b expected 00000000", c, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_stability();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmux_nway_stream.md
# dmux_nway_stream

Parametrised, registered N-way demultiplexer with valid/ready flow control. It steers each accepted word to one of `NUM_WAYS = 2**SEL_W` output channels chosen by a per-word select. An internal two-entry skid buffer sustains one transfer per cycle under back-pressure. It is the next generation of the combinational DMux tree and feeds RAM-bank and peripheral write ports that can stall.

## Interface
Parameters:
- `WIDTH`, default 16: data word width in bits; must be 1 or more.
- `SEL_W`, default 3: select width in bits; must be 1 or more. `NUM_WAYS = 2**SEL_W` is derived locally, so the default is 8 ways.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid`, input, 1: the upstream word is valid this cycle.
- `in_ready`, output, 1: the block can accept a word this cycle.
- `in_sel`, input, `SEL_W`: destination way for the upstream word.
- `in_data`, input, `WIDTH`: upstream data word.
- `out_valid`, output, `NUM_WAYS`: per-way valid. At most one bit is set at any time.
- `out_ready`, input, `NUM_WAYS`: per-way ready from the downstream consumers.
- `out_data`, output, `NUM_WAYS*WIDTH`: per-way data lanes. Way k occupies bits `[k*WIDTH +: WIDTH]`.
- `busy`, output, 1: high when either buffer entry holds a word.

## Operation
- State consists of two entries, each holding `{valid, sel, data}`:
  - main: the entry currently driving the outputs.
  - skid: the overflow entry.
- Input acceptance: a word is accepted when `in_valid && in_ready` at a rising edge.
- Output transfer: the main entry drains when `out_valid[main.sel] && out_ready[main.sel]` at a rising edge.
- Output drive:
  - `out_valid = main.valid ? (1 << main.sel) : 0`.
  - `out_ready` bits of non-selected ways are ignored.
- `in_ready = !skid.valid`. It depends only on state, with no combinational path from `in_valid` or `out_ready`.
- Buffer states and transitions:
  - EMPTY (main and skid both empty):
    - accept → ONE.
  - ONE (main full, skid empty):
    - accept and drain → stay ONE; main takes the new word.
    - accept without drain → TWO; the new word goes into skid.
    - drain without accept → EMPTY.
  - TWO (main and skid both full; `in_ready`=0):
    - drain → ONE; skid moves into main and skid becomes empty.
    - no drain → hold both entries.
- Ordering: words leave in acceptance order across all ways.
  - A stalled way blocks later words to other ways (head-of-line blocking). This is intended and is the simplest ordering rule.
- Stability: while `out_valid[k]`=1 and `out_ready[k]`=0, both `out_valid` and lane k of `out_data` hold their values.
- `busy = main.valid || skid.valid`.
- Reset (`rst_n`=0 at an edge):
  - both valid flags clear.
  - any words held, including mid-stall, are discarded.
  - sel and data registers clear to 0.
  - `in_valid` is ignored in the reset cycle.

## Timing
- Latency: a word accepted at edge N appears on `out_valid`/`out_data` after edge N, i.e. in cycle N+1, provided the block was in EMPTY or drained at edge N.
- Throughput: one word per cycle sustained while the selected way keeps `out_ready` high.
- After a stall ends, a buffered word is presented in the cycle following the edge at which the previous word drained.
- Values after reset:
  - `out_valid`=0.
  - `out_data`=0.
  - `in_ready`=1.
  - `busy`=0.
- Maximum occupancy is two words. `in_ready` falls in the cycle after the edge that fills skid.

## Configuration
- Macro: `DMUX_ZERO_UNSEL_EN`.
- Defined:
  - Every lane other than `main.sel` is driven to 0.
  - Lane `main.sel` carries `main.data` only while `main.valid`=1; otherwise all lanes are 0.
  - This matches gate-level DMux semantics.
- Undefined:
  - All lanes carry `main.data` (broadcast), and `out_valid` alone qualifies them.
  - This mode saves the per-lane AND gating.
- Handshake behaviour and timing are identical in both modes.

## Test plan
All scenarios use the default parameters, `WIDTH`=16 and `SEL_W`=3.
1. Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1 → `out_valid`=0, `out_data`=0, `in_ready`=1 and `busy`=0 after release.
2. Single transfer:
   - Stimulus: `in_sel`=5, `in_data`=16'hA5A5 with all `out_ready`=1.
   - Response: `out_valid`=8'b0010_0000 and lane 5 = A5A5 for exactly one cycle.
   - With `DMUX_ZERO_UNSEL_EN` defined, all other lanes are 0; undefined, all lanes show A5A5.
3. Streaming: send sel 0..7 back-to-back with data 0x10+sel and all ready → one-hot valid walks bit 0 to bit 7 on consecutive cycles with matching data and `in_ready` never low.
4. Back-pressure:
   - Stimulus: `out_ready[2]`=0, then send sel 2 (data 0x1), sel 3 (0x2) and sel 4 (0x3).
   - Response: `in_ready` goes low after the second word is accepted; the third word waits.
   - Release `out_ready[2]` → order at the outputs is 0x1 (way 2), 0x2 (way 3), 0x3 (way 4), with no loss or duplication.
5. Stability: stall way 6 for 5 cycles → `out_valid` and lane 6 are held constant; toggling `out_ready` of other ways has no effect.
6. Reset mid-operation: with the buffer in TWO, pulse `rst_n`=0 for one cycle → `busy`=0 and `out_valid`=0 on the next cycle; the held words never appear.
